// File: rtl/branch_unit.sv
// Branch resolution: architectural E/GT flags, compare-pending tracking, b/beq/bgt/call/ret, redirect handshake.
// Optional `BRANCH_FLAG_BYPASS_EN lets beq/bgt resolve on the live cmp_eq/cmp_gt in the cycle cmp_valid is high.
module branch_unit #(
  parameter int PC_W    = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmp_issue,
  input  logic               cmp_valid,
  input  logic               cmp_eq,
  input  logic               cmp_gt,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [2:0]         br_op,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [PC_W-1:0]    br_offset,
  input  logic [PC_W-1:0]    ra_in,
  output logic               flag_e,
  output logic               flag_gt,
  output logic               br_done,
  output logic               br_taken,
  output logic               ra_we,
  output logic [PC_W-1:0]    ra_wdata,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [2:0] OP_B    = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BGT  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic [1:0]         state_q, state_d;
  logic               pend_q, pend_d;
  logic               flag_e_q, flag_e_d;
  logic               flag_gt_q, flag_gt_d;
  logic [2:0]         op_q, op_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    off_q, off_d;
  logic [PC_W-1:0]    ra_q, ra_d;
  logic               done_q, done_d;
  logic               taken_q, taken_d;
  logic               ra_we_q, ra_we_d;
  logic [PC_W-1:0]    ra_wdata_q, ra_wdata_d;
  logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic               in_idle;
  logic               accept;
  logic [2:0]         op_s;
  logic [PC_W-1:0]    pc_s;
  logic [PC_W-1:0]    off_s;
  logic [PC_W-1:0]    ra_s;
  logic               flag_op;
  logic               byp;
  logic               e_use;
  logic               gt_use;
  logic               cond_taken;
  logic [PC_W-1:0]    target;
  logic               resolve;
  logic               stall_inc;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle && br_valid;

  // In IDLE the request is resolved straight off the ports; in WAIT off the latched copy.
  assign op_s  = in_idle ? br_op     : op_q;
  assign pc_s  = in_idle ? br_pc     : pc_q;
  assign off_s = in_idle ? br_offset : off_q;
  assign ra_s  = in_idle ? ra_in     : ra_q;

  assign flag_op = (op_s == OP_BEQ) || (op_s == OP_BGT);

`ifdef BRANCH_FLAG_BYPASS_EN
  assign byp = cmp_valid;
`else
  assign byp = 1'b0;
`endif

  assign e_use  = byp ? cmp_eq : flag_e_q;
  assign gt_use = byp ? cmp_gt : flag_gt_q;

  always_comb begin
    cond_taken = 1'b0;
    case (op_s)
      OP_B, OP_CALL, OP_RET: cond_taken = 1'b1;
      OP_BEQ:                cond_taken = e_use;
      OP_BGT:                cond_taken = gt_use;
      default:               cond_taken = 1'b0;
    endcase
  end

  assign target = (op_s == OP_RET) ? ra_s : (pc_s + (off_s << 2));

  always_comb begin
    resolve = 1'b0;
    if (accept) begin
      resolve = !(flag_op && pend_q && !byp);
    end else if (state_q == S_WAIT) begin
      resolve = byp || !pend_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (resolve) state_d = cond_taken ? S_OUT : S_IDLE;
          else         state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resolve) state_d = cond_taken ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An issue and a result in the same cycle belong to different compares, so the bit stays set.
  assign pend_d    = cmp_issue || (pend_q && !cmp_valid);
  assign flag_e_d  = cmp_valid ? cmp_eq : flag_e_q;
  assign flag_gt_d = cmp_valid ? cmp_gt : flag_gt_q;

  always_comb begin
    op_d  = op_q;
    pc_d  = pc_q;
    off_d = off_q;
    ra_d  = ra_q;
    if (accept) begin
      op_d  = br_op;
      pc_d  = br_pc;
      off_d = br_offset;
      ra_d  = ra_in;
    end
  end

  always_comb begin
    done_d     = resolve;
    taken_d    = resolve && cond_taken;
    ra_we_d    = resolve && (op_s == OP_CALL);
    ra_wdata_d = ra_we_d ? (pc_s + PC_W'(4)) : ra_wdata_q;
    rd_pc_d    = (resolve && cond_taken) ? target : rd_pc_q;
  end

  assign stall_inc = (state_q == S_WAIT) || ((state_q == S_OUT) && !redirect_ready);

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != {STALL_W{1'b1}})) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      flag_e_q   <= 1'b0;
      flag_gt_q  <= 1'b0;
      op_q       <= 3'b000;
      pc_q       <= '0;
      off_q      <= '0;
      ra_q       <= '0;
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      ra_we_q    <= 1'b0;
      ra_wdata_q <= '0;
      rd_pc_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      flag_e_q   <= flag_e_d;
      flag_gt_q  <= flag_gt_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      off_q      <= off_d;
      ra_q       <= ra_d;
      done_q     <= done_d;
      taken_q    <= taken_d;
      ra_we_q    <= ra_we_d;
      ra_wdata_q <= ra_wdata_d;
      rd_pc_q    <= rd_pc_d;
      stall_q    <= stall_d;
    end
  end

  assign br_ready       = in_idle;
  assign flag_e         = flag_e_q;
  assign flag_gt        = flag_gt_q;
  assign br_done        = done_q;
  assign br_taken       = taken_q;
  assign ra_we          = ra_we_q;
  assign ra_wdata       = ra_wdata_q;
  assign redirect_valid = (state_q == S_OUT);
  assign redirect_pc    = rd_pc_q;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboarded bench for branch_unit; expected resolutions are queued at accept and checked at br_done.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmp_issue = 1'b0, cmp_valid = 1'b0, cmp_eq = 1'b0, cmp_gt = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_op = 3'b000;
  logic [31:0] br_pc = '0, br_offset = '0, ra_in = '0;
  logic        flag_e, flag_gt, br_done, br_taken, ra_we;
  logic [31:0] ra_wdata;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          taken;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  branch_unit #(.PC_W(32), .STALL_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmp_issue(cmp_issue), .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .br_pc(br_pc),
    .br_offset(br_offset), .ra_in(ra_in), .flag_e(flag_e), .flag_gt(flag_gt),
    .br_done(br_done), .br_taken(br_taken), .ra_we(ra_we), .ra_wdata(ra_wdata),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(bit t, bit w, logic [31:0] wd, logic [31:0] tg);
    exp_t r;
    r.taken = t; r.we = w; r.wdata = wd; r.tgt = tg;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmp_issue = 0; cmp_valid = 0; cmp_eq = 0; cmp_gt = 0;
    br_valid = 0; br_op = 3'b000; br_pc = '0; br_offset = '0; ra_in = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic drive_br(logic [2:0] op, logic [31:0] pc, logic [31:0] off, logic [31:0] ra);
    br_valid = 1'b1; br_op = op; br_pc = pc; br_offset = off; ra_in = ra;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (br_ready !== 1'b1) begin miscompares++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
    vectors++; if (br_done !== 1'b0) begin miscompares++; $display("FAIL reset_br_done: got %b want 0", br_done); end
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    vectors++; if ({flag_e, flag_gt} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {flag_e, flag_gt}); end
    vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    vectors++; if ({ra_we, br_taken} !== 2'b00 || ra_wdata !== 32'd0 || redirect_pc !== 32'd0) begin
      miscompares++; $display("FAIL reset_data: got we=%b tk=%b wd=%h pc=%h want all 0", ra_we, br_taken, ra_wdata, redirect_pc);
    end
  endtask

  task automatic test_beq_taken();
    do_reset();
    redirect_ready = 1'b1;
    cmp_valid = 1; cmp_eq = 1; cmp_gt = 0;
    tick();
    cmp_valid = 0;
    vectors++; if ({flag_e, flag_gt} !== 2'b10) begin miscompares++; $display("FAIL beq_flags: got %b want 10", {flag_e, flag_gt}); end
    drive_br(3'b010, 32'h100, 32'd4, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'h110));
    vectors++; if (br_ready !== 1'b1) begin miscompares++; $display("FAIL beq_ready: got %b want 1", br_ready); end
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL beq_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_pc !== e.tgt || redirect_valid !== 1'b1) begin
        miscompares++; $display("FAIL beq_result: got tk=%b pc=%h rv=%b want tk=%b pc=%h rv=1", br_taken, redirect_pc, redirect_valid, e.taken, e.tgt);
      end
    end
    tick();
    vectors++; if (br_done !== 1'b0 || redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
      miscompares++; $display("FAIL beq_after: got done=%b rv=%b rdy=%b want 0 0 1", br_done, redirect_valid, br_ready);
    end
  endtask

  task automatic test_bgt();
    do_reset();
    redirect_ready = 1'b1;
    cmp_valid = 1; cmp_eq = 0; cmp_gt = 0;
    tick();
    cmp_valid = 0;
    drive_br(3'b011, 32'h40, 32'd8, 32'h0);
    sb.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL bgt_nt_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
        miscompares++; $display("FAIL bgt_nt: got tk=%b rv=%b rdy=%b want tk=%b rv=0 rdy=1", br_taken, redirect_valid, br_ready, e.taken);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL bgt_nt_rv: got %b want 0 at +%0d", redirect_valid, i); end
    end
    // bgt taken with a negative offset
    cmp_valid = 1; cmp_eq = 0; cmp_gt = 1;
    tick();
    cmp_valid = 0;
    drive_br(3'b011, 32'h40, 32'hFFFF_FFFF, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'h3C));
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL bgt_t_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_pc !== e.tgt) begin
        miscompares++; $display("FAIL bgt_t: got tk=%b pc=%h want tk=%b pc=%h", br_taken, redirect_pc, e.taken, e.tgt);
      end
    end
    tick();
  endtask

  task automatic test_dependent();
    do_reset();
    redirect_ready = 1'b1;
    cmp_issue = 1;
    tick();
    cmp_issue = 0; cmp_valid = 1; cmp_eq = 1; cmp_gt = 0;
    drive_br(3'b010, 32'h300, 32'd1, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'h304));
    vectors++; if (br_ready !== 1'b1) begin miscompares++; $display("FAIL dep_ready: got %b want 1", br_ready); end
    tick();
    cmp_valid = 0; br_valid = 0;
`ifndef BRANCH_FLAG_BYPASS_EN
    vectors++; if (br_done !== 1'b0 || redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL dep_early: got done=%b rv=%b want 0 0", br_done, redirect_valid);
    end
    tick();
`endif
    vectors++;
    if (br_done !== 1'b1 || redirect_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL dep_done: got done=%b rv=%b want 1 1", br_done, redirect_valid);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_pc !== e.tgt) begin
        miscompares++; $display("FAIL dep_result: got tk=%b pc=%h want tk=%b pc=%h", br_taken, redirect_pc, e.taken, e.tgt);
      end
    end
`ifdef BRANCH_FLAG_BYPASS_EN
    vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL dep_stall: got %0d want 0", stall_cycles); end
`else
    vectors++; if (stall_cycles !== 16'd1) begin miscompares++; $display("FAIL dep_stall: got %0d want 1", stall_cycles); end
`endif
    tick();
  endtask

  task automatic test_pend_hold();
    // issue+valid together keeps the bit set; the branch must wait for the later result (eq=0)
    do_reset();
    redirect_ready = 1'b1;
    cmp_issue = 1; cmp_valid = 1; cmp_eq = 1;
    tick();
    cmp_issue = 0; cmp_valid = 0;
    drive_br(3'b010, 32'h80, 32'd2, 32'h0);
    sb.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    br_valid = 0;
    vectors++; if (br_done !== 1'b0 || br_ready !== 1'b0) begin
      miscompares++; $display("FAIL pend_wait: got done=%b rdy=%b want 0 0", br_done, br_ready);
    end
    cmp_valid = 1; cmp_eq = 0; cmp_gt = 0;
    tick();
    cmp_valid = 0;
`ifndef BRANCH_FLAG_BYPASS_EN
    vectors++; if (br_done !== 1'b0) begin miscompares++; $display("FAIL pend_early: got %b want 0", br_done); end
    tick();
`endif
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL pend_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_valid !== 1'b0) begin
        miscompares++; $display("FAIL pend_result: got tk=%b rv=%b want tk=%b rv=0", br_taken, redirect_valid, e.taken);
      end
    end
`ifdef BRANCH_FLAG_BYPASS_EN
    vectors++; if (stall_cycles !== 16'd1) begin miscompares++; $display("FAIL pend_stall: got %0d want 1", stall_cycles); end
`else
    vectors++; if (stall_cycles !== 16'd2) begin miscompares++; $display("FAIL pend_stall: got %0d want 2", stall_cycles); end
`endif
    tick();
  endtask

  task automatic test_call();
    int we_cnt;
    do_reset();
    redirect_ready = 1'b0;
    we_cnt = 0;
    drive_br(3'b100, 32'h200, 32'hFFFF_FFFE, 32'h0);
    sb.push_back(mk(1'b1, 1'b1, 32'h204, 32'h1F8));
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL call_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || ra_we !== e.we || ra_wdata !== e.wdata) begin
        miscompares++; $display("FAIL call_ra: got tk=%b we=%b wd=%h want tk=%b we=%b wd=%h", br_taken, ra_we, ra_wdata, e.taken, e.we, e.wdata);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) redirect_ready = 1'b1;
      if (ra_we === 1'b1) we_cnt++;
      vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1F8 || br_ready !== 1'b0) begin
        miscompares++; $display("FAIL call_hold: got rv=%b pc=%h rdy=%b want 1 1f8 0 at %0d", redirect_valid, redirect_pc, br_ready, i);
      end
      tick();
    end
    if (ra_we === 1'b1) we_cnt++;
    vectors++; if (we_cnt != 1) begin miscompares++; $display("FAIL call_we_count: got %0d want 1", we_cnt); end
    vectors++; if (redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
      miscompares++; $display("FAIL call_release: got rv=%b rdy=%b want 0 1", redirect_valid, br_ready);
    end
    vectors++; if (stall_cycles !== 16'd3) begin miscompares++; $display("FAIL call_stall: got %0d want 3", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    redirect_ready = 1'b1;
    drive_br(3'b101, 32'h500, 32'd7, 32'hFFFF_FFFC);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC));
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL ret_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_pc !== e.tgt || ra_we !== e.we) begin
        miscompares++; $display("FAIL ret_result: got tk=%b pc=%h we=%b want tk=%b pc=%h we=%b", br_taken, redirect_pc, ra_we, e.taken, e.tgt, e.we);
      end
    end
    tick();
    vectors++; if (br_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", br_ready); end
    drive_br(3'b001, 32'hFFFF_FFF8, 32'd3, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0000_0004));
    tick();
    br_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL wrap_done: got %b want 1", br_done);
    end else begin
      e = sb.pop_front();
      if (br_taken !== e.taken || redirect_pc !== e.tgt) begin
        miscompares++; $display("FAIL wrap_result: got tk=%b pc=%h want tk=%b pc=%h", br_taken, redirect_pc, e.taken, e.tgt);
      end
    end
    tick();
  endtask

  task automatic test_reset_in_out();
    do_reset();
    redirect_ready = 1'b0;
    cmp_valid = 1; cmp_eq = 1; cmp_gt = 1;
    drive_br(3'b001, 32'h10, 32'd1, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 32'h14));
    tick();
    br_valid = 0; cmp_valid = 0;
    vectors++;
    if (br_done !== 1'b1 || redirect_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL rst_out_setup: got done=%b rv=%b want 1 1", br_done, redirect_valid);
    end else begin
      e = sb.pop_front();
      if (redirect_pc !== e.tgt) begin miscompares++; $display("FAIL rst_out_pc: got %h want %h", redirect_pc, e.tgt); end
    end
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    redirect_ready = 1'b1;
    vectors++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0 || br_done !== 1'b0 || redirect_pc !== 32'd0 || {flag_e, flag_gt} !== 2'b00) begin
      miscompares++; $display("FAIL rst_out_state: got rdy=%b rv=%b done=%b pc=%h fl=%b want 1 0 0 0 00", br_ready, redirect_valid, br_done, redirect_pc, {flag_e, flag_gt});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (redirect_valid !== 1'b0 || br_done !== 1'b0) begin
        miscompares++; $display("FAIL rst_out_stale: got rv=%b done=%b want 0 0 at %0d", redirect_valid, br_done, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bgt();
    test_dependent();
    test_pend_hold();
    test_call();
    test_back_to_back();
    test_reset_in_out();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch-resolution stage directly downstream of `adder_sub`. It holds the architectural E/GT flags written by compare results (`Eq`/`Gt`) and resolves `b`, `beq`, `bgt`, `call` and `ret`. It tracks an in-flight compare so a flag-dependent branch never resolves on stale flags, and presents the redirect target to fetch over a valid/ready handshake.

## Interface
- `PC_W`, 32, program counter, offset and target width
- `STALL_W`, 16, width of the saturating stall counter
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `cmp_issue`  in  1  a `cmp` entered `adder_sub` this cycle
- `cmp_valid`  in  1  compare result is valid this cycle
- `cmp_eq`  in  1  `Eq` from `adder_sub`
- `cmp_gt`  in  1  `Gt` from `adder_sub`
- `br_valid`  in  1  branch request valid
- `br_ready`  out  1  branch request accepted when high with `br_valid`
- `br_op`  in  3  000 nop, 001 b, 010 beq, 011 bgt, 100 call, 101 ret, 110/111 nop
- `br_pc`  in  PC_W  PC of the branch
- `br_offset`  in  PC_W  sign-extended word offset
- `ra_in`  in  PC_W  current `ra` value, used by `ret`
- `flag_e`, `flag_gt`  out  1  architectural flags
- `br_done`  out  1  one-cycle pulse when a branch resolves
- `br_taken`  out  1  valid with `br_done`
- `ra_we`  out  1  one-cycle `ra` write pulse, asserted for `call`
- `ra_wdata`  out  PC_W  `br_pc + 4`
- `redirect_valid`  out  1  redirect presented to fetch
- `redirect_ready`  in  1  fetch accepts the redirect
- `redirect_pc`  out  PC_W  target address
- `stall_cycles`  out  STALL_W  saturating stall count

## Operation
- Reset (while `reset`=0 at an edge): every output is 0 except `br_ready`, which is 1. State returns to IDLE, the pending bit is cleared, and any in-flight branch is dropped with no `br_done`.
- Flags: if `cmp_valid`=1, `flag_e` and `flag_gt` load `cmp_eq` and `cmp_gt` at the next edge.
- Pending bit: set by `cmp_issue` and cleared by `cmp_valid`. If both are asserted in the same cycle, the bit stays set. Upstream must not assert `cmp_issue` while the state is not IDLE.
- States: IDLE, WAIT_FLAGS, OUT. `br_ready` is 1 only in IDLE.
- Accepting a request in IDLE latches `br_op`, `br_pc`, `br_offset` and `ra_in`.
- An accepted `beq`/`bgt` goes to WAIT_FLAGS if the pending bit is set and no bypass applies. Every other accepted request resolves in the accept cycle.
- Taken condition: `b`, `call` and `ret` are always taken. `beq` is taken on E. `bgt` is taken on GT. Nops are never taken.
- Target: `ret` uses the latched `ra_in`. All others use `br_pc + (br_offset << 2)`, computed mod 2^PC_W (wraps, no overflow flag).
- On resolve: pulse `br_done` with `br_taken`. For `call`, also pulse `ra_we` with `ra_wdata`; this happens regardless of `redirect_ready`. Next state is OUT if taken, otherwise IDLE.
- OUT: `redirect_valid`=1 and `redirect_pc` is held stable until `redirect_ready`=1. After that handshake the state returns to IDLE.
- `stall_cycles` increments in every cycle spent in WAIT_FLAGS, and in every OUT cycle with `redirect_ready`=0. It saturates at all-ones.

## Timing
- Request accepted in cycle N with no dependency: `br_done`, `ra_we` and `redirect_valid` are registered and appear in N+1. The earliest next accept is N+2 (taken branch with `redirect_ready`=1), or N+1 (not-taken branch).
- Scenario: `cmp_issue` in N, then `beq` accepted in N+1 with `cmp_valid` in N+1. Without bypass, the result appears in N+3. With bypass, it appears in N+2.
- In WAIT_FLAGS without bypass, the branch resolves in the first cycle the pending bit is 0, using the registered flags.
- An `adder_sub` Result/Cout does not affect this block.

## Configuration
- `BRANCH_FLAG_BYPASS_EN` defined: when `cmp_valid`=1, `beq`/`bgt` resolve on `cmp_eq`/`cmp_gt` in that same cycle. This applies both at accept and in WAIT_FLAGS, and removes one stall cycle.
- Undefined: flag-dependent branches use only the registered flags. A branch that sees the pending bit set always spends at least one cycle in WAIT_FLAGS.

## Test plan
- Hold `reset`=0 for 2 cycles during an OUT handshake, then release → all outputs 0, `br_ready`=1, no stale redirect afterward.
- `cmp_valid` with eq=1, gt=0 (25 vs 25), then `beq` pc=0x100, offset=4 → next cycle `br_done`=1, `br_taken`=1, `redirect_pc`=0x110.
- `cmp_valid` with eq=0, gt=0 (10 vs 20), then `bgt` pc=0x40 → `br_done`=1, `br_taken`=0, `redirect_valid` never asserts, `br_ready`=1 one cycle after accept.
- `cmp_issue` in N, `beq` in N+1, `cmp_valid` with eq=1 in N+1 → `redirect_valid` in N+3 without the macro, N+2 with it. `stall_cycles`=1 without the macro, 0 with it.
- `call` pc=0x200, offset=-2, `redirect_ready` held low 3 cycles → `ra_we` pulses once with 0x204, `redirect_pc`=0x1F8 stable for 4 cycles, `br_ready`=0 throughout, `stall_cycles`=3.
- `ret` with `ra_in`=0xFFFFFFFC, and `b` pc=0xFFFFFFF8, offset=3 → targets 0xFFFFFFFC and 0x00000004 (wrap).
